multi_alarm_ctrl: RTL
=====================

Name: multi_alarm_ctrl

Overview:
Parametrised alarm manager with N_ALARM independently armed alarm slots.
- Compares each slot against the running clock time and drives a ring/snooze/dismiss state machine.
- Outputs drive the melody enable and the alarm LED.
- Sits between the time-keeping block (time_now source), the adjust block (slot write port) and the melody/LED outputs. It replaces the single fixed alarm register and single-cycle compare in the top level.

Parameters:
N_ALARM, 4, number of alarm slots (1..16); IDXW = max(1, clog2(N_ALARM)) is a derived localparam.
SNOOZE_MIN, 5, snooze length in minutes (1..59).
RING_TIMEOUT_S, 60, seconds of continuous ringing before auto-stop (1..255).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
tick_1hz  in  1  one-clk-wide pulse once per second.
time_now  in  16  current time {hour[15:8], min[7:0]}, binary, 24-hour.
wr_en  in  1  slot write strobe.
wr_idx  in  IDXW  slot to write.
wr_time  in  16  alarm time {hour, min}.
wr_arm  in  1  arm bit for the written slot.
rd_idx  in  IDXW  slot readback select.
rd_time  out  16  time of slot rd_idx (combinational).
rd_arm  out  1  arm bit of slot rd_idx (combinational).
snooze  in  1  debounced, edge-detected snooze pulse.
dismiss  in  1  debounced, edge-detected dismiss pulse.
ring  out  1  melody enable.
ring_idx  out  IDXW  slot currently ringing or snoozed.
led  out  1  alarm LED, blinking while ringing.
snoozed  out  1  high while in SNOOZE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - all slots time = 16'h0000, arm = 0;
  - state = IDLE; ring = led = snoozed = 0; ring_idx = 0;
  - sec_cnt = 0; snooze_time = 0; time_prev = 0.
- Slot write: on wr_en, slot wr_idx takes wr_time and wr_arm on the next clk edge.
  - Write is ignored if hour > 23, min > 59, or wr_idx >= N_ALARM.
- Readback: rd_idx >= N_ALARM reads 0.
- Minute-entry detect: time_prev is registered every clk. new_min = (time_now != time_prev).
- Match: hit[i] = new_min && arm[i] && (slot[i] == time_now).
  - Only entry into the minute triggers, so a dismissed alarm does not retrigger within the same minute.
  - Several hits in the same cycle: lowest index wins; the others are dropped.
- FSM IDLE:
  - any hit -> RING; ring_idx = winner, sec_cnt = 0, ring = 1 and led = 1 in the next cycle.
- FSM RING:
  - ring = 1. led toggles on each tick_1hz. sec_cnt increments on each tick_1hz.
  - dismiss -> IDLE.
  - snooze -> SNOOZE; snooze_time = time_now + SNOOZE_MIN. Minutes wrap at 60 and carry into the hour; hour wraps 23 -> 0.
  - sec_cnt reaching RING_TIMEOUT_S on a tick -> IDLE (auto-stop, no snooze).
  - Hits are ignored while in RING.
- FSM SNOOZE:
  - ring = 0, led = 0, snoozed = 1.
  - new_min && time_now == snooze_time -> RING; same ring_idx, sec_cnt = 0.
  - dismiss -> IDLE.
  - Any hit -> RING with the new winner; the pending snooze is discarded.
- Exit to IDLE: ring, led and snoozed all read 0 on the next cycle. sec_cnt is cleared.
- Simultaneous events:
  - dismiss and snooze together: dismiss wins.
  - dismiss together with a hit while in SNOOZE: dismiss wins and the hit is dropped.
- Writing arm = 0 to slot ring_idx while in RING or SNOOZE forces IDLE next cycle. Writing a new time with arm = 1 does not stop ringing.
- Reset asserted mid-ring: all outputs drop to 0 immediately (asynchronous). All slots are cleared.
- Arithmetic: snooze_time is computed in binary with explicit minute/hour wrap. sec_cnt is 8 bits and saturates at RING_TIMEOUT_S.

Optional Feature:
ALARM_WEEKDAY_EN
- Defined: adds input day_now[2:0] (0 = Mon .. 6 = Sun), input wr_days[6:0] and output rd_days[6:0].
  - Each slot stores a 7-bit day mask, written with wr_time; reset value 7'h7F.
  - A hit additionally requires days[i][day_now] = 1. day_now = 7 never matches.
  - Snooze re-ring ignores the day mask.
- Undefined: these ports and mask registers are absent and every armed slot matches daily.

Test Plan:
1. Slot1 = 07:30 armed, slot0 = 07:30 armed, time_now steps 07:29 -> 07:30 -> ring = 1 next cycle, ring_idx = 0, led toggles per tick_1hz.
2. Ring on slot2 = 23:58 with SNOOZE_MIN = 5, snooze pulse at 23:58 -> snoozed = 1, ring = 0; time 00:02 no ring; 00:03 -> ring = 1, ring_idx = 2.
3. Ringing, 60 tick_1hz pulses with RING_TIMEOUT_S = 60 -> ring = 0 after the 60th tick. Time held at the same minute -> no retrigger.
4. Ringing, snooze and dismiss in the same cycle -> IDLE, snoozed = 0, ring = 0.
5. Write wr_time = 24:00 or 12:60 -> rd_time unchanged. Write arm = 0 to the ringing slot -> ring = 0 next cycle.
6. rst_n low mid-ring, asynchronous to clk -> ring = led = snoozed = 0 immediately; rd_arm = 0 for all slots. With ALARM_WEEKDAY_EN, mask 7'b0000001 and day_now = 1 -> no ring at the matching time.

Source files
------------

// File: rtl/multi_alarm_ctrl.sv
// multi_alarm_ctrl: N-slot alarm manager with ring/snooze/dismiss FSM; optional ALARM_WEEKDAY_EN adds per-slot day masks
module multi_alarm_ctrl #(
    parameter int N_ALARM        = 4,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    localparam int IDXW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick_1hz,
    input  logic [15:0]     time_now,
`ifdef ALARM_WEEKDAY_EN
    input  logic [2:0]      day_now,
    input  logic [6:0]      wr_days,
    output logic [6:0]      rd_days,
`endif
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [15:0]     wr_time,
    input  logic            wr_arm,
    input  logic [IDXW-1:0] rd_idx,
    output logic [15:0]     rd_time,
    output logic            rd_arm,
    input  logic            snooze,
    input  logic            dismiss,
    output logic            ring,
    output logic [IDXW-1:0] ring_idx,
    output logic            led,
    output logic            snoozed
);
    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
    state_t               state;
    logic [15:0]          slot_time [N_ALARM];
    logic [N_ALARM-1:0]   slot_arm;
    logic [15:0]          time_prev, snooze_time;
    logic [7:0]           sec_cnt, snz_min, snz_hour;
    logic [N_ALARM-1:0]   hit;
    logic [IDXW-1:0]      winner;
    logic                 new_min, wr_ok, disarm, any_hit, rd_ok;
`ifdef ALARM_WEEKDAY_EN
    logic [6:0]           slot_days [N_ALARM];
    logic [7:0]           day_mask;
`endif

    assign new_min = time_now != time_prev;
    assign wr_ok   = wr_en && wr_time[15:8] <= 8'd23 && wr_time[7:0] <= 8'd59 && int'(wr_idx) < N_ALARM;
    assign disarm  = wr_ok && !wr_arm && wr_idx == ring_idx;
    assign any_hit = |hit;
    assign rd_ok   = int'(rd_idx) < N_ALARM;
    assign rd_time = rd_ok ? slot_time[rd_idx] : 16'h0000;
    assign rd_arm  = rd_ok ? slot_arm[rd_idx] : 1'b0;
`ifdef ALARM_WEEKDAY_EN
    assign rd_days = rd_ok ? slot_days[rd_idx] : 7'h00;
`endif

    // Per-slot match on minute entry; the lowest matching index wins
    always_comb begin
        hit    = '0;
        winner = '0;
`ifdef ALARM_WEEKDAY_EN
        day_mask = 8'h00;
`endif
        for (int i = 0; i < N_ALARM; i++) begin
`ifdef ALARM_WEEKDAY_EN
            day_mask = {1'b0, slot_days[i]};
            hit[i] = new_min && slot_arm[i] && slot_time[i] == time_now && day_mask[day_now];
`else
            hit[i] = new_min && slot_arm[i] && slot_time[i] == time_now;
`endif
        end
        for (int i = N_ALARM - 1; i >= 0; i--)
            if (hit[i]) winner = IDXW'(i);
    end

    // Snooze wake time: add SNOOZE_MIN with minute and hour wrap
    always_comb begin
        snz_min  = time_now[7:0] + 8'(SNOOZE_MIN);
        snz_hour = time_now[15:8];
        if (snz_min >= 8'd60) begin
            snz_min  = snz_min - 8'd60;
            snz_hour = snz_hour + 8'd1;
        end
        if (snz_hour >= 8'd24) snz_hour = 8'd0;
    end

    // Slot storage, ignoring out-of-range times and indices
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_arm <= '0;
            for (int i = 0; i < N_ALARM; i++) begin
                slot_time[i] <= 16'h0000;
`ifdef ALARM_WEEKDAY_EN
                slot_days[i] <= 7'h7F;
`endif
            end
        end else if (wr_ok) begin
            slot_time[wr_idx] <= wr_time;
            slot_arm[wr_idx]  <= wr_arm;
`ifdef ALARM_WEEKDAY_EN
            slot_days[wr_idx] <= wr_days;
`endif
        end
    end

    // Ring/snooze/dismiss FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ring        <= 1'b0;
            led         <= 1'b0;
            snoozed     <= 1'b0;
            ring_idx    <= '0;
            sec_cnt     <= '0;
            snooze_time <= '0;
            time_prev   <= '0;
        end else begin
            time_prev <= time_now;
            case (state)
                IDLE: if (any_hit) begin
                    state    <= RING;
                    ring_idx <= winner;
                    sec_cnt  <= '0;
                    ring     <= 1'b1;
                    led      <= 1'b1;
                end
                RING: if (dismiss || disarm) begin
                    state   <= IDLE;
                    ring    <= 1'b0;
                    led     <= 1'b0;
                    sec_cnt <= '0;
                end else if (snooze) begin
                    state       <= SNOOZE;
                    snooze_time <= {snz_hour, snz_min};
                    ring        <= 1'b0;
                    led         <= 1'b0;
                    snoozed     <= 1'b1;
                    sec_cnt     <= '0;
                end else if (tick_1hz) begin
                    if (sec_cnt >= 8'(RING_TIMEOUT_S - 1)) begin
                        state   <= IDLE;
                        ring    <= 1'b0;
                        led     <= 1'b0;
                        sec_cnt <= '0;
                    end else begin
                        sec_cnt <= sec_cnt + 8'd1;
                        led     <= ~led;
                    end
                end
                SNOOZE: if (dismiss || disarm) begin
                    state   <= IDLE;
                    snoozed <= 1'b0;
                end else if (any_hit || (new_min && time_now == snooze_time)) begin
                    state    <= RING;
                    ring_idx <= any_hit ? winner : ring_idx;
                    sec_cnt  <= '0;
                    ring     <= 1'b1;
                    led      <= 1'b1;
                    snoozed  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
